// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-issue instruction fetch stage: owns the PC, fetches one word per request,
// resolves beq/bne at retire. Optional fetch timeout enabled by FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr_o,
  output logic                instr_valid_o,
  output logic [31:0]         pc_o,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic                bne_i,
  input  logic                zero_i,
  output logic                fetch_err_o
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2, ERR = 2'd3} state_t;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cnt_expire;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4, branch_off, target;
  logic        taken;

  // Branch offset is the word-scaled, sign-extended 16-bit immediate.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    target     = pc_plus4 + branch_off;
    taken      = (branch_i & zero_i) | (bne_i & ~zero_i);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
    cnt_expire = ({{(32-CNT_W){1'b0}}, cnt_q} + 32'd1) >= TIMEOUT_CYCLES;
`endif
    unique case (state_q)
      IDLE: begin
        state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_data;
          state_d = VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          // An ack arriving on the expiry cycle takes the branch above instead.
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_expire) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
`endif
      end
      VALID: begin
        if (!stall_i) begin
          pc_d    = taken ? target : pc_plus4;
          state_d = REQ;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERR: state_d = ERR;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Request decodes straight from the state register so reset drops it at once.
  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = pc_q;
  assign instr_o        = instr_q;
  assign instr_valid_o  = (state_q == VALID);
  assign pc_o           = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err_o    = err_q;
`else
  assign fetch_err_o    = 1'b0;
`endif

endmodule
